// File: rtl/button_conditioner_if.sv
// Purpose: bundle of raw button inputs and conditioned outputs between the
//          panel front end (master) and the alarm controller (slave).
// Latency: none (wires only); backpressure: none, every strobe is a one-cycle pulse.
//
// Members:
//   btn_n        raw active-low buttons, asynchronous to clk (slave drives)
//   tick_1ms     one-cycle tick strobe shared with the controller
//   btn_level    debounced level, 1 = held
//   btn_press    one-cycle strobe on accepted press
//   btn_release  one-cycle strobe on accepted release
//   btn_step     one-cycle strobe on press or auto-repeat
interface button_conditioner_if #(
    parameter int N_BTN = 3
);
    logic [N_BTN-1:0] btn_n;
    logic             tick_1ms;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic [N_BTN-1:0] btn_step;

    // The conditioner: consumes raw buttons, produces conditioned signals.
    modport master (
        input  btn_n,
        output tick_1ms,
        output btn_level,
        output btn_press,
        output btn_release,
        output btn_step
    );

    // The consumer side (controller / panel model): drives raw buttons.
    modport slave (
        output btn_n,
        input  tick_1ms,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  btn_step
    );
endinterface

// File: rtl/button_conditioner.sv
// Purpose: synchronise, debounce and edge-detect active-low push buttons; export a 1 ms tick.
// Latency: raw edge -> strobe is 2 clk + DEBOUNCE_MS ticks (at most 2 + (DEBOUNCE_MS+1)*TICK_DIV clk).
// Backpressure: none; press/release/step/tick are one-cycle strobes the consumer must take.
//
// Ports:
//   clk   system clock
//   rst   synchronous reset, active-high
//   bus   button_conditioner_if.master (btn_n in; tick_1ms, btn_level,
//         btn_press, btn_release, btn_step out)
// Build option: define BUTTON_AUTOREPEAT_EN to add per-button auto-repeat on
// btn_step; without it btn_step is exactly btn_press.
module button_conditioner #(
    parameter int N_BTN           = 3,
    parameter int TICK_DIV        = 50000,
    parameter int DEBOUNCE_MS     = 20,
    parameter int REPEAT_DELAY_MS = 500,
    parameter int REPEAT_RATE_MS  = 100
) (
    input  logic                   clk,
    input  logic                   rst,
    button_conditioner_if.master   bus
);

    // Reject parameter values the counters below cannot honour.
    if (TICK_DIV < 2) begin : g_bad_tick_div
        $error("button_conditioner: TICK_DIV must be >= 2");
    end
    if (DEBOUNCE_MS < 1) begin : g_bad_debounce
        $error("button_conditioner: DEBOUNCE_MS must be >= 1");
    end
    if (REPEAT_RATE_MS < 1) begin : g_bad_rate
        $error("button_conditioner: REPEAT_RATE_MS must be >= 1");
    end
    if (REPEAT_DELAY_MS < 1) begin : g_bad_delay
        $error("button_conditioner: REPEAT_DELAY_MS must be >= 1");
    end

    localparam int DIV_W = $clog2(TICK_DIV);        // holds 0..TICK_DIV-1
    localparam int DB_W  = $clog2(DEBOUNCE_MS + 1); // holds 0..DEBOUNCE_MS

    // ------------------------------------------------------------------
    // Tick divider
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    assign tick = (div_cnt == DIV_W'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Two-flop synchroniser on the raw active-low inputs. Preset to 1 so
    // that reset looks like "all released".
    // ------------------------------------------------------------------
    logic [N_BTN-1:0] sync1;
    logic [N_BTN-1:0] sync2;
    logic [N_BTN-1:0] s;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= bus.btn_n;
            sync2 <= sync1;
        end
    end

    assign s = ~sync2;

    // ------------------------------------------------------------------
    // Debounce: a new level must differ from the accepted one on
    // DEBOUNCE_MS consecutive ticks. Any tick that agrees restarts the count.
    // ------------------------------------------------------------------
    logic [DB_W-1:0]  db_cnt [N_BTN];
    logic [N_BTN-1:0] level_q;
    logic [N_BTN-1:0] press_q;
    logic [N_BTN-1:0] rel_q;
    logic [N_BTN-1:0] accept;

    always_comb begin
        accept = '0;
        for (int b = 0; b < N_BTN; b++) begin
            accept[b] = tick && (s[b] != level_q[b]) &&
                        ((int'(db_cnt[b]) + 1) >= DEBOUNCE_MS);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= '0;
            press_q <= '0;
            rel_q   <= '0;
            for (int b = 0; b < N_BTN; b++) begin
                db_cnt[b] <= '0;
            end
        end else begin
            // Strobes land on the same edge that moves the level.
            level_q <= (level_q & ~accept) | (s & accept);
            press_q <= accept & s;
            rel_q   <= accept & ~s;
            for (int b = 0; b < N_BTN; b++) begin
                if (tick) begin
                    if ((s[b] == level_q[b]) || accept[b]) begin
                        db_cnt[b] <= '0;
                    end else begin
                        db_cnt[b] <= db_cnt[b] + DB_W'(1);
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Auto-repeat
    // ------------------------------------------------------------------
    logic [N_BTN-1:0] rep_strobe;

`ifdef BUTTON_AUTOREPEAT_EN
    localparam int RP_MAX = (REPEAT_DELAY_MS > REPEAT_RATE_MS) ? REPEAT_DELAY_MS
                                                                : REPEAT_RATE_MS;
    localparam int RP_W   = $clog2(RP_MAX + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DELAY  = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    logic [1:0]       rp_state [N_BTN];
    logic [RP_W-1:0]  rp_cnt   [N_BTN];
    logic [N_BTN-1:0] rep_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rep_q <= '0;
            for (int b = 0; b < N_BTN; b++) begin
                rp_state[b] <= ST_IDLE;
                rp_cnt[b]   <= '0;
            end
        end else begin
            for (int b = 0; b < N_BTN; b++) begin
                rep_q[b] <= 1'b0;
                // A release being accepted on this very edge wins over a
                // repeat that would otherwise fall due on the same tick.
                if ((accept[b] && !s[b]) || !level_q[b]) begin
                    rp_state[b] <= ST_IDLE;
                    rp_cnt[b]   <= '0;
                end else begin
                    case (rp_state[b])
                        ST_IDLE: begin
                            if (press_q[b]) begin
                                rp_state[b] <= ST_DELAY;
                                rp_cnt[b]   <= '0;
                            end
                        end
                        ST_DELAY: begin
                            if (tick) begin
                                if ((int'(rp_cnt[b]) + 1) >= REPEAT_DELAY_MS) begin
                                    rep_q[b]    <= 1'b1;
                                    rp_state[b] <= ST_REPEAT;
                                    rp_cnt[b]   <= '0;
                                end else begin
                                    rp_cnt[b] <= rp_cnt[b] + RP_W'(1);
                                end
                            end
                        end
                        ST_REPEAT: begin
                            if (tick) begin
                                if ((int'(rp_cnt[b]) + 1) >= REPEAT_RATE_MS) begin
                                    rep_q[b]  <= 1'b1;
                                    rp_cnt[b] <= '0;
                                end else begin
                                    rp_cnt[b] <= rp_cnt[b] + RP_W'(1);
                                end
                            end
                        end
                        default: begin
                            rp_state[b] <= ST_IDLE;
                            rp_cnt[b]   <= '0;
                        end
                    endcase
                end
            end
        end
    end

    assign rep_strobe = rep_q;
`else
    assign rep_strobe = '0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.tick_1ms    = tick;
    assign bus.btn_level   = level_q;
    assign bus.btn_press   = press_q;
    assign bus.btn_release = rel_q;
    assign bus.btn_step    = press_q | rep_strobe;

endmodule
